// File: rtl/wb_arbiter_if.sv
// rtl/wb_arbiter_if.sv - result/write-back bus bundle between producers, the arbiter and the register file
interface wb_arbiter_if;
    logic        alu_valid;
    logic [2:0]  alu_dest;
    logic [15:0] alu_data;
    logic        alu_ready;
    logic        ld_valid;
    logic [2:0]  ld_dest;
    logic [15:0] ld_data;
    logic        ld_ready;
    logic        write_en;
    logic [2:0]  write_dest;
    logic [15:0] write_data;
    logic [7:0]  pend_mask;

    modport master (
        output alu_valid, alu_dest, alu_data, ld_valid, ld_dest, ld_data,
        input  alu_ready, ld_ready, write_en, write_dest, write_data, pend_mask
    );

    modport slave (
        input  alu_valid, alu_dest, alu_data, ld_valid, ld_dest, ld_data,
        output alu_ready, ld_ready, write_en, write_dest, write_data, pend_mask
    );
endinterface

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - write-back arbiter: one-entry ALU slot plus in-order load FIFO onto one register write port
// Optional pending-register tracking on pend_mask is enabled by defining WB_PEND_MASK_EN.
module wb_arbiter #(
    parameter int LD_DEPTH = 2
) (
    input logic         clk,
    input logic         rst,
    wb_arbiter_if.slave bus
);
    localparam int PW = $clog2(LD_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(LD_DEPTH);

    localparam logic [1:0] SEL_NONE = 2'd0;
    localparam logic [1:0] SEL_ALU  = 2'd1;
    localparam logic [1:0] SEL_FIFO = 2'd2;

    logic          alu_vld_q, alu_vld_d;
    logic [2:0]    alu_dest_q, alu_dest_d;
    logic [15:0]   alu_data_q, alu_data_d;
    logic [2:0]    fifo_dest_q [LD_DEPTH];
    logic [2:0]    fifo_dest_d [LD_DEPTH];
    logic [15:0]   fifo_data_q [LD_DEPTH];
    logic [15:0]   fifo_data_d [LD_DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          write_en_q, write_en_d;
    logic [2:0]    write_dest_q, write_dest_d;
    logic [15:0]   write_data_q, write_data_d;

    logic          alu_acc, ld_acc, pop;
    logic [1:0]    sel;
    logic [2:0]    drain_dest;
    logic [15:0]   drain_data;

    assign bus.alu_ready  = !alu_vld_q && !rst;
    assign bus.ld_ready   = (count_q < DEPTH_C) && !rst;
    assign bus.write_en   = write_en_q;
    assign bus.write_dest = write_dest_q;
    assign bus.write_data = write_data_q;

    always_comb begin
        alu_acc = bus.alu_valid && bus.alu_ready;
        ld_acc  = bus.ld_valid && bus.ld_ready;

        // A full FIFO outranks the ALU so loads cannot be starved indefinitely.
        if (count_q == DEPTH_C)   sel = SEL_FIFO;
        else if (alu_vld_q)       sel = SEL_ALU;
        else if (count_q != '0)   sel = SEL_FIFO;
        else                      sel = SEL_NONE;

        pop        = (sel == SEL_FIFO);
        drain_dest = (sel == SEL_ALU) ? alu_dest_q : fifo_dest_q[rd_ptr_q];
        drain_data = (sel == SEL_ALU) ? alu_data_q : fifo_data_q[rd_ptr_q];

        alu_vld_d  = alu_vld_q && (sel != SEL_ALU);
        alu_dest_d = alu_dest_q;
        alu_data_d = alu_data_q;
        if (alu_acc) begin
            alu_vld_d  = 1'b1;
            alu_dest_d = bus.alu_dest;
            alu_data_d = bus.alu_data;
        end

        fifo_dest_d = fifo_dest_q;
        fifo_data_d = fifo_data_q;
        if (ld_acc) begin
            fifo_dest_d[wr_ptr_q] = bus.ld_dest;
            fifo_data_d[wr_ptr_q] = bus.ld_data;
        end
        rd_ptr_d = rd_ptr_q + PW'(pop);
        wr_ptr_d = wr_ptr_q + PW'(ld_acc);
        count_d  = count_q + CW'(ld_acc) - CW'(pop);

        // Register 0 is hardwired: its results are consumed without a write.
        write_en_d   = (sel != SEL_NONE) && (drain_dest != 3'd0);
        write_dest_d = write_en_d ? drain_dest : write_dest_q;
        write_data_d = write_en_d ? drain_data : write_data_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            alu_vld_q    <= 1'b0;
            alu_dest_q   <= '0;
            alu_data_q   <= '0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            write_en_q   <= 1'b0;
            write_dest_q <= '0;
            write_data_q <= '0;
        end else begin
            alu_vld_q    <= alu_vld_d;
            alu_dest_q   <= alu_dest_d;
            alu_data_q   <= alu_data_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            write_en_q   <= write_en_d;
            write_dest_q <= write_dest_d;
            write_data_q <= write_data_d;
        end
    end

    always_ff @(posedge clk) begin
        fifo_dest_q <= fifo_dest_d;
        fifo_data_q <= fifo_data_d;
    end

`ifdef WB_PEND_MASK_EN
    logic [7:0]    pend;
    logic [PW-1:0] off;

    always_comb begin
        pend = 8'h00;
        off  = '0;
        if (alu_vld_q) pend[alu_dest_q] = 1'b1;
        for (int i = 0; i < LD_DEPTH; i++) begin
            off = PW'(i) - rd_ptr_q;
            if ({1'b0, off} < count_q) pend[fifo_dest_q[i]] = 1'b1;
        end
        if (write_en_q) pend[write_dest_q] = 1'b1;
        pend[0] = 1'b0;
    end

    assign bus.pend_mask = pend;
`else
    assign bus.pend_mask = 8'h00;
`endif
endmodule
